// File: rtl/lineattr_writer_if.sv
// Span request channel and line attribute buffer write port for lineattr_writer.
// The span source and scanline control sit on the master side.
// The writer itself sits on the slave side.
interface lineattr_writer_if;
  logic        line_start;
  logic        span_valid;
  logic        span_ready;
  logic [8:0]  span_x;
  logic [15:0] span_mask;
  logic [8:0]  idx1;
  logic        wrdata1;
  logic        wren1;
  logic        busy;

  modport master (
    output line_start, span_valid, span_x, span_mask,
    input  span_ready, idx1, wrdata1, wren1, busy
  );

  modport slave (
    input  line_start, span_valid, span_x, span_mask,
    output span_ready, idx1, wrdata1, wren1, busy
  );
endinterface

// File: rtl/lineattr_writer.sv
// Line attribute writer.
// On line_start it clears a 512x1 attribute buffer.
// It then accepts 16-wide spans and writes a 1 at each masked index.
// Every output is a flop, so no input reaches an output in the same cycle.
module lineattr_writer (
  input  logic              clk,
  input  logic              reset,
  lineattr_writer_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, CLEAR, ACCEPT, WRITE} state_t;

  state_t      state_reg, state_next;
  logic [8:0]  idx_reg, idx_next;
  logic        wrdata_reg, wrdata_next;
  logic        wren_reg, wren_next;
  logic        ready_reg, ready_next;
  logic        busy_reg, busy_next;
  logic [15:0] mask_reg, mask_next;   // remaining mask bits, bit 0 is the next write
  logic [3:0]  cnt_reg, cnt_next;     // position i within the current span

  // Next-state and next-output logic.
  // line_start overrides everything below it.
  always_comb begin
    state_next  = state_reg;
    idx_next    = idx_reg;
    wrdata_next = wrdata_reg;
    wren_next   = 1'b0;
    ready_next  = 1'b0;
    mask_next   = mask_reg;
    cnt_next    = cnt_reg;

    case (state_reg)
      IDLE: begin
      end
      CLEAR: begin
        if (idx_reg == 9'd511) begin
          state_next  = ACCEPT;
          ready_next  = 1'b1;
          wrdata_next = 1'b1;           // data returns to 1 once the clear is done
        end else begin
          idx_next    = idx_reg + 9'd1;
          wren_next   = 1'b1;
          wrdata_next = 1'b0;
        end
      end
      ACCEPT: begin
        ready_next = 1'b1;
        if (bus.span_valid && ready_reg) begin
          state_next  = WRITE;
          ready_next  = 1'b0;
          idx_next    = bus.span_x;
          wren_next   = bus.span_mask[0];
          wrdata_next = 1'b1;
          mask_next   = bus.span_mask >> 1;
          cnt_next    = 4'd0;
        end
      end
      WRITE: begin
        if (cnt_reg == 4'd15) begin
          state_next = ACCEPT;
          ready_next = 1'b1;
        end else begin
          idx_next  = idx_reg + 9'd1;   // 9-bit wrap, carry dropped
          wren_next = mask_reg[0];
          mask_next = mask_reg >> 1;
          cnt_next  = cnt_reg + 4'd1;
        end
      end
      default: state_next = IDLE;
    endcase

    if (bus.line_start) begin
      state_next  = CLEAR;
      idx_next    = 9'd0;
      wren_next   = 1'b1;
      wrdata_next = 1'b0;
      ready_next  = 1'b0;
      cnt_next    = 4'd0;
    end

    busy_next = (state_next == CLEAR) || (state_next == WRITE);
  end

  // State and output registers.
  // Reset wins over any pending line_start.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      idx_reg    <= 9'd0;
      wrdata_reg <= 1'b0;
      wren_reg   <= 1'b0;
      ready_reg  <= 1'b0;
      busy_reg   <= 1'b0;
      mask_reg   <= 16'd0;
      cnt_reg    <= 4'd0;
    end else begin
      state_reg  <= state_next;
      idx_reg    <= idx_next;
      wrdata_reg <= wrdata_next;
      wren_reg   <= wren_next;
      ready_reg  <= ready_next;
      busy_reg   <= busy_next;
      mask_reg   <= mask_next;
      cnt_reg    <= cnt_next;
    end
  end

  assign bus.idx1       = idx_reg;
  assign bus.wrdata1    = wrdata_reg;
  assign bus.wren1      = wren_reg;
  assign bus.span_ready = ready_reg;
  assign bus.busy       = busy_reg;

endmodule

// File: tb/tb_lineattr_writer.sv
// Self-checking bench for lineattr_writer.
// A 512-bit observed bitmap is built from the write port.
// An expected bitmap is built from the span rules: a clear zeroes every
// entry, and a span sets entry (x+i) mod 512 for each set mask bit.
module tb_lineattr_writer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  lineattr_writer_if bus();

  lineattr_writer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_compared   = 0;
  int n_mismatched = 0;
  logic [511:0] obs_map;
  logic [511:0] exp_map;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and capture the write port into the bitmap.
  task automatic tick();
    @(negedge clk);
    if (bus.wren1 === 1'b1) obs_map[bus.idx1] = bus.wrdata1;
  endtask

  // Called in the first cycle after line_start was sampled.
  // It walks the 512 clear writes and ends in the first ACCEPT cycle.
  task automatic check_clear();
    for (int k = 0; k < 512; k++) begin
      check("clr_idx",    512'(bus.idx1),       512'(k));
      check("clr_wren",   512'(bus.wren1),      512'(1));
      check("clr_wrdata", 512'(bus.wrdata1),    512'(0));
      check("clr_ready",  512'(bus.span_ready), 512'(0));
      check("clr_busy",   512'(bus.busy),       512'(1));
      bus.span_x    = 9'($urandom);
      bus.span_mask = 16'($urandom);
      tick();
    end
    check("acc_ready", 512'(bus.span_ready), 512'(1));
    check("acc_wren",  512'(bus.wren1),      512'(0));
    check("acc_busy",  512'(bus.busy),       512'(0));
    exp_map = '0;
    check("bitmap_clear", obs_map, exp_map);
  endtask

  task automatic start_line();
    bus.line_start = 1'b1;
    tick();
    bus.line_start = 1'b0;
    $display("line_start: clearing 512 entries");
    check_clear();
  endtask

  // Issue one span from an ACCEPT cycle.
  // abort_at >= 0 pulses line_start during WRITE cycle i == abort_at.
  task automatic send_span(input logic [8:0] x, input logic [15:0] m, input int abort_at);
    int ix;
    $display("span x=%0d mask=%04h abort_at=%0d", x, m, abort_at);
    check("hs_ready", 512'(bus.span_ready), 512'(1));
    bus.span_valid = 1'b1;
    bus.span_x     = x;
    bus.span_mask  = m;
    tick();
    for (int i = 0; i < 16; i++) begin
      ix = (int'(x) + i) % 512;
      // Junk requests while span_ready is low must be ignored.
      bus.span_valid = 1'($urandom_range(0, 1));
      bus.span_x     = 9'($urandom);
      bus.span_mask  = 16'($urandom);
      check("wr_idx",   512'(bus.idx1),       512'(ix));
      check("wr_wren",  512'(bus.wren1),      512'(m[i]));
      if (bus.wren1 === 1'b1) check("wr_data", 512'(bus.wrdata1), 512'(1));
      check("wr_ready", 512'(bus.span_ready), 512'(0));
      check("wr_busy",  512'(bus.busy),       512'(1));
      if (m[i]) exp_map[ix] = 1'b1;
      if (i == abort_at) begin
        bus.span_valid = 1'b0;
        bus.line_start = 1'b1;
        tick();
        bus.line_start = 1'b0;
        check_clear();
        return;
      end
      if (i == 15) bus.span_valid = 1'b0;
      tick();
    end
    check("done_ready", 512'(bus.span_ready), 512'(1));
    check("done_wren",  512'(bus.wren1),      512'(0));
    check("done_busy",  512'(bus.busy),       512'(0));
    check("bitmap_span", obs_map, exp_map);
  endtask

  task automatic idle_gap(input int n);
    bus.span_valid = 1'b0;
    for (int k = 0; k < n; k++) begin
      check("gap_ready", 512'(bus.span_ready), 512'(1));
      check("gap_wren",  512'(bus.wren1),      512'(0));
      tick();
    end
  endtask

  initial begin
    logic [15:0] m;
    bus.line_start = 1'b0;
    bus.span_valid = 1'b0;
    bus.span_x     = '0;
    bus.span_mask  = '0;
    obs_map = '0;
    exp_map = '0;
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;

    // After reset the block idles and ignores spans until a line_start.
    bus.span_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("rst_idx",    512'(bus.idx1),       512'(0));
      check("rst_wrdata", 512'(bus.wrdata1),    512'(0));
      check("rst_wren",   512'(bus.wren1),      512'(0));
      check("rst_ready",  512'(bus.span_ready), 512'(0));
      check("rst_busy",   512'(bus.busy),       512'(0));
      tick();
    end
    bus.span_valid = 1'b0;

    start_line();
    send_span(9'h010, 16'h8001, -1);
    send_span(9'd510, 16'hFFFF, -1);
    send_span(9'($urandom), 16'h0000, -1);
    idle_gap(5);

    // Abort during WRITE cycle i=5.
    send_span(9'($urandom), 16'hFFFF, 5);

    // line_start together with a handshake: the clear wins.
    $display("line_start with simultaneous handshake");
    bus.span_valid = 1'b1;
    bus.span_x     = 9'($urandom);
    bus.span_mask  = 16'hFFFF;
    bus.line_start = 1'b1;
    tick();
    bus.line_start = 1'b0;
    bus.span_valid = 1'b0;
    check_clear();

    // Reset at clear index 200, with line_start and span_valid also high.
    $display("reset mid-clear at idx1=200");
    bus.line_start = 1'b1;
    tick();
    bus.line_start = 1'b0;
    bus.span_valid = 1'b1;
    repeat (200) tick();
    check("pre_rst_idx", 512'(bus.idx1), 512'(200));
    reset = 1'b1;
    bus.line_start = 1'b1;
    tick();
    reset = 1'b0;
    bus.line_start = 1'b0;
    for (int k = 0; k < 20; k++) begin
      check("mrst_idx",    512'(bus.idx1),       512'(0));
      check("mrst_wrdata", 512'(bus.wrdata1),    512'(0));
      check("mrst_wren",   512'(bus.wren1),      512'(0));
      check("mrst_ready",  512'(bus.span_ready), 512'(0));
      check("mrst_busy",   512'(bus.busy),       512'(0));
      tick();
    end
    // span_valid stays high through the new clear and is honoured only afterwards.
    start_line();
    send_span(9'($urandom), 16'($urandom), -1);

    // Randomized spans with gaps and occasional new lines.
    for (int n = 0; n < 24; n++) begin
      idle_gap($urandom_range(0, 3));
      if (n % 8 == 7) start_line();
      m = ($urandom_range(0, 4) == 0) ? 16'h0000 : 16'($urandom);
      send_span(9'($urandom), m, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
